// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline-boundary registers.
// Control-bit positions are common to every stage boundary.
package pipe_pkg;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  localparam int CTRL_W_IFID  = 1;
  localparam int CTRL_W_IDEX  = 4;
  localparam int CTRL_W_EXMEM = 3;
  localparam int CTRL_W_MEMWB = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } slotState_e;

endpackage

// File: rtl/pipe_slot.sv
// One valid bit plus payload register. Clear outranks load, so a flush
// always wins over a beat arriving on the same edge.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] nextPay,
  output logic         vld_p1,
  output logic [W-1:0] pay_p1
);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      pay_p1 <= '0;
    end else if (clear) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1 <= 1'b1;
      pay_p1 <= nextPay;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register with valid/ready handshake, optional 2-entry
// skid buffer, synchronous flush and control gating on bubbles.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_DATA = 2,
  parameter int REG_W    = REG_W_DEF,
  parameter int CTRL_W   = CTRL_W_EXMEM,
  parameter int SKID_EN  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]           in_reg,
  input  logic [CTRL_W-1:0]          in_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [REG_W-1:0]           out_reg,
  output logic [CTRL_W-1:0]          out_ctrl
);

  localparam int PAY_W = NUM_DATA*DATA_W + REG_W + CTRL_W;

  logic [PAY_W-1:0]  inPay, mainNext, mainPay_p1, skidPay_p1;
  logic              mainVld_p1, skidVld_p1;
  logic              mainLoad, mainClear, skidLoad, skidClear;
  logic              accept, emit;
  logic [CTRL_W-1:0] ctrlHeld;
  slotState_e        state;

  assign inPay  = {in_data, in_reg, in_ctrl};
  assign accept = in_valid && in_ready;
  assign emit   = mainVld_p1 && out_ready;

  // Occupancy lives in the slot valid bits; the state is decoded from them.
  always_comb begin
    state     = ST_EMPTY;
    mainLoad  = 1'b0;
    mainClear = 1'b0;
    skidLoad  = 1'b0;
    skidClear = 1'b0;
    mainNext  = inPay;
    if (skidVld_p1)      state = ST_FULL;
    else if (mainVld_p1) state = ST_ONE;
    unique case (state)
      ST_EMPTY: mainLoad = accept;
      ST_ONE: begin
        if (accept && emit) mainLoad  = 1'b1;
        else if (accept)    skidLoad  = 1'b1;
        else if (emit)      mainClear = 1'b1;
      end
      ST_FULL: begin
        if (emit) begin
          mainLoad  = 1'b1;
          mainNext  = skidPay_p1;
          skidClear = 1'b1;
        end
      end
      default: ;
    endcase
    if (flush) begin
      mainClear = 1'b1;
      skidClear = 1'b1;
    end
  end

  // Stage boundary: main register feeding the downstream stage.
  pipe_slot #(.W(PAY_W)) mainSlot (
    .clk     (clk),
    .rst     (rst),
    .load    (mainLoad),
    .clear   (mainClear),
    .nextPay (mainNext),
    .vld_p1  (mainVld_p1),
    .pay_p1  (mainPay_p1)
  );

  generate
    if (SKID_EN != 0) begin : gSkid
      pipe_slot #(.W(PAY_W)) skidSlot (
        .clk     (clk),
        .rst     (rst),
        .load    (skidLoad),
        .clear   (skidClear),
        .nextPay (inPay),
        .vld_p1  (skidVld_p1),
        .pay_p1  (skidPay_p1)
      );
      // Driven straight from a flop: no path from out_ready.
      assign in_ready = !skidVld_p1;
    end else begin : gNoSkid
      logic unusedSkidCtl;
      assign unusedSkidCtl = skidLoad ^ skidClear;
      assign skidVld_p1    = 1'b0;
      assign skidPay_p1    = '0;
      assign in_ready      = !mainVld_p1 || out_ready;
    end
  endgenerate

  assign {out_data, out_reg, ctrlHeld} = mainPay_p1;
  assign out_valid = mainVld_p1;
  assign out_ctrl  = mainVld_p1 ? ctrlHeld : '0;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-boundary register; successor to the fixed EX/MEM latch. Carries NUM_DATA data words, one destination-register index and a control-bit vector between two pipeline stages. Adds a valid/ready handshake, an optional 2-entry skid buffer, a synchronous flush, and bubble-safe control gating. Instanced at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
DATA_W, 32, width of each data word
NUM_DATA, 2, number of data words carried (EX/MEM: ALUOut, WriteData)
REG_W, 5, destination register index width
CTRL_W, 3, control bit count (EX/MEM: RegWrite, MemtoReg, MemWrite)
SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous kill of all held and incoming beats
in_valid  in  1  upstream beat present
in_ready  out  1  stage can accept a beat this cycle
in_data  in  NUM_DATA*DATA_W  packed data words, word 0 in LSBs
in_reg  in  REG_W  destination register index
in_ctrl  in  CTRL_W  control bits
out_valid  out  1  downstream beat present
out_ready  in  1  downstream accepts beat
out_data  out  NUM_DATA*DATA_W  held data words
out_reg  out  REG_W  held register index
out_ctrl  out  CTRL_W  held control bits, forced 0 when out_valid=0

Behaviour:
- Clock: clk only. Reset: rst synchronous, active-high. Priority: rst > flush > normal.
- Reset: out_valid=0; out_data, out_reg, out_ctrl=0; skid slot empty. in_ready=1 the cycle after rst deasserts.
- Accept: beat accepted when in_valid && in_ready at rising edge. Emit: beat consumed when out_valid && out_ready.
- Latency: accepted beat appears on out_* the next cycle. Throughput: 1 beat/cycle while out_ready=1.
- Payload regs load only on accept. No load on idle cycles, so out_data holds stable while stalled.
- Bubble safety: out_ctrl = main_valid ? ctrl_q : 0. RegWrite/MemWrite can never assert on a bubble.
- SKID_EN=1:
  - States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
  - in_ready = (state != FULL), registered, with no combinational path from out_ready.
  - EMPTY + accept -> ONE.
  - ONE + accept + emit -> ONE, main loads input.
  - ONE + accept + no emit -> FULL, input goes to skid.
  - ONE + emit only -> EMPTY.
  - FULL + emit -> ONE, main loads skid, skid cleared. FULL never accepts.
  - Order is preserved: the skid beat always precedes the next input.
- SKID_EN=0: single slot. in_ready = !out_valid || out_ready (combinational). Simultaneous emit+accept reloads the slot the same edge.
- Flush: next cycle out_valid=0, skid empty, state EMPTY. A beat offered in the flush cycle is discarded even if in_ready=1. in_ready=1 the cycle after flush. Payload regs may retain stale values; out_ctrl is still 0.
- Flush during a stall in FULL: both beats dropped, no emit.
- rst mid-transfer: identical to flush, plus payload regs cleared to 0.
- Width rules: all widths ≥ 1. NUM_DATA=1 is legal. No arithmetic in this block.

Decomposition:
- Shared package pipe_pkg:
  - ctrl bit index constants CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMWRITE=2
  - default widths DATA_W_DEF=32, REG_W_DEF=5
  - per-boundary CTRL_W constants
- One sub-module, pipe_slot: a single valid+payload register with load/clear inputs. Instanced once for main and once for skid (the skid instance only when SKID_EN=1).

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, out_ctrl=0; in_ready=1 the first cycle after rst drops.
- Streaming: SKID_EN=1, out_ready=1, beats A..E (in_data=0x0000_0001..5, ctrl=3'b001) -> each out 1 cycle later in order, no gaps, in_ready stays 1.
- Back-pressure: accept A, drop out_ready, offer B, C -> B captured in skid, in_ready=0 next cycle, C held upstream; raise out_ready -> out sequence A, B, C with no loss or duplication.
- Flush in FULL: holding A (main) and B (skid), assert flush with C offered -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never emitted.
- Bubble gating: ctrl=3'b111 beat consumed, in_valid=0 -> next cycle out_valid=0 and out_ctrl=3'b000 while out_data retains the last value.
- SKID_EN=0: out_ready=0 with a valid held beat -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> reload on the same edge, out_valid remains 1.
